// File: rtl/wb_pkg.sv
// Shared types and sizing helpers for the pipelined Wishbone block RAM.
package wb_pkg;

  localparam int unsigned WB_ADDR_W = 32;
  localparam int unsigned WB_MAX_DATA_W = 64;

  typedef struct packed {
    logic                       cyc;
    logic                       stb;
    logic                       we;
    logic [WB_ADDR_W-1:0]       addr;
    logic [WB_MAX_DATA_W-1:0]   data;
    logic [WB_MAX_DATA_W/8-1:0] sel;
  } wb_req_t;

  typedef struct packed {
    logic                     ack;
    logic                     err;
    logic [WB_MAX_DATA_W-1:0] data;
  } wb_rsp_t;

  // Number of byte lanes in a data word.
  function automatic int unsigned lane_cnt(int unsigned data_w);
    return data_w / 8;
  endfunction

  // Word-index width for a RAM of size_byte bytes.
  function automatic int unsigned word_aw(int unsigned size_byte, int unsigned data_w);
    return $clog2(size_byte / (data_w / 8));
  endfunction

endpackage

// File: rtl/bram_lane.sv
// One 8-bit true-dual-port read-first RAM lane.
module bram_lane #(
  parameter int AW = 11
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_a_en,
  input  logic          i_a_we,
  input  logic [AW-1:0] i_a_addr,
  input  logic [7:0]    i_a_wd,
  output logic [7:0]    o_a_rd,
  input  logic          i_b_en,
  input  logic          i_b_we,
  input  logic [AW-1:0] i_b_addr,
  input  logic [7:0]    i_b_wd,
  output logic [7:0]    o_b_rd
);

  logic [7:0] r_mem [2**AW];
  logic [7:0] r_a_rd;
  logic [7:0] r_b_rd;

  // Array writes; the top masks port B so both ports never write this lane at one address together.
  always_ff @(posedge i_clk) begin
    if (i_a_en && i_a_we) r_mem[i_a_addr] <= i_a_wd;
    if (i_b_en && i_b_we) r_mem[i_b_addr] <= i_b_wd;
  end

  // Read registers sample the pre-write contents, giving read-first behaviour on both ports.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a_rd <= '0;
      r_b_rd <= '0;
    end else begin
      if (i_a_en) r_a_rd <= r_mem[i_a_addr];
      if (i_b_en) r_b_rd <= r_mem[i_b_addr];
    end
  end

  assign o_a_rd = r_a_rd;
  assign o_b_rd = r_b_rd;

endmodule

// File: rtl/wb_bram_pipelined.sv
// Dual-port RAM: Wishbone B4 pipelined slave on port A, native word port on port B.
module wb_bram_pipelined
  import wb_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter int          SIZE_BYTE  = 8192,
  parameter logic [31:0] START_ADDR = 32'h20000000,
  parameter int          RD_LAT     = 1
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_wb_cyc,
  input  logic                                i_wb_stb,
  input  logic [31:0]                         i_wb_addr,
  input  logic                                i_wb_we,
  input  logic [DATA_W-1:0]                   i_wb_data,
  input  logic [DATA_W/8-1:0]                 i_wb_sel,
  output logic                                o_wb_ack,
  output logic                                o_wb_err,
  output logic [DATA_W-1:0]                   o_wb_data,
  output logic                                o_wb_stall,
  input  logic                                i_b_en,
  input  logic [DATA_W/8-1:0]                 i_b_we,
  input  logic [word_aw(SIZE_BYTE,DATA_W)-1:0] i_b_addr,
  input  logic [DATA_W-1:0]                   i_b_wd,
  output logic [DATA_W-1:0]                   o_b_rd,
  output logic                                o_b_coll
);

  localparam int NB = lane_cnt(DATA_W);
  localparam int AW = word_aw(SIZE_BYTE, DATA_W);
  localparam int BW = $clog2(NB);
  localparam int SW = $clog2(SIZE_BYTE);

  if ((START_ADDR & 32'(SIZE_BYTE - 1)) != 32'd0) begin : g_bad_base
    $fatal(1, "wb_bram_pipelined: START_ADDR not aligned to SIZE_BYTE");
  end
  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_width
    $fatal(1, "wb_bram_pipelined: DATA_W must be 32 or 64");
  end
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $fatal(1, "wb_bram_pipelined: RD_LAT must be 1 or 2");
  end

  logic              w_req;
  logic              w_in_range;
  logic              w_a_en;
  logic [AW-1:0]     w_a_word;
  logic [NB-1:0]     w_a_we;
  logic [NB-1:0]     w_coll;
  logic [NB-1:0]     w_b_we;
  logic [DATA_W-1:0] w_a_rd;
  logic [DATA_W-1:0] w_b_rd;
  logic [DATA_W-1:0] w_a_data;
  logic [DATA_W-1:0] w_mask;
  logic              w_unused;

  logic [RD_LAT-1:0] r_vld;
  logic [RD_LAT-1:0] r_err;
  logic [NB-1:0]     r_sel [RD_LAT];
  logic              r_b_coll;

  // Byte-offset bits are ignored; sel carries the lane alignment.
  assign w_unused   = &{1'b0, i_wb_addr[BW-1:0]};

  assign w_req      = i_wb_cyc & i_wb_stb;
  assign w_in_range = (i_wb_addr[31:SW] == START_ADDR[31:SW]);
  assign w_a_word   = i_wb_addr[SW-1:BW];
  assign w_a_en     = w_req & w_in_range;
  assign w_a_we     = (w_a_en && i_wb_we) ? i_wb_sel : '0;
  // Lanes written by both ports at the same word go to Wishbone; port B keeps its other lanes.
  assign w_coll     = (i_b_en && (i_b_addr == w_a_word)) ? (w_a_we & i_b_we) : '0;
  assign w_b_we     = i_b_en ? (i_b_we & ~w_coll) : '0;

  for (genvar g = 0; g < NB; g++) begin : g_lane
    bram_lane #(.AW(AW)) u_lane (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_a_en   (w_a_en),
      .i_a_we   (w_a_we[g]),
      .i_a_addr (w_a_word),
      .i_a_wd   (i_wb_data[8*g +: 8]),
      .o_a_rd   (w_a_rd[8*g +: 8]),
      .i_b_en   (i_b_en),
      .i_b_we   (w_b_we[g]),
      .i_b_addr (i_b_addr),
      .i_b_wd   (i_b_wd[8*g +: 8]),
      .o_b_rd   (w_b_rd[8*g +: 8])
    );
  end

  // Response shift register; write acks carry sel=0 so they drive zero data, and an abort clears everything in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld <= '0;
      r_err <= '0;
      for (int i = 0; i < RD_LAT; i++) r_sel[i] <= '0;
    end else begin
      r_vld[0] <= w_req;
      r_err[0] <= ~w_in_range;
      r_sel[0] <= i_wb_we ? '0 : i_wb_sel;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_err[i] <= r_err[i-1];
        r_sel[i] <= r_sel[i-1];
      end
      if (!i_wb_cyc) r_vld <= '0;
    end
  end

  // Collision flag lines up with the RAM read data of the colliding access.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_b_coll <= 1'b0;
    else          r_b_coll <= |w_coll;
  end

  if (RD_LAT == 2) begin : g_out_reg
    logic [DATA_W-1:0] r_a_rd_q;
    logic [DATA_W-1:0] r_b_rd_q;
    // Extra output stage behind the raw BRAM registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_a_rd_q <= '0;
        r_b_rd_q <= '0;
      end else begin
        r_a_rd_q <= w_a_rd;
        r_b_rd_q <= w_b_rd;
      end
    end
    assign w_a_data = r_a_rd_q;
    assign o_b_rd   = r_b_rd_q;
  end else begin : g_out_raw
    assign w_a_data = w_a_rd;
    assign o_b_rd   = w_b_rd;
  end

  // Expand the response's lane selects to a bit mask.
  always_comb begin
    w_mask = '0;
    for (int n = 0; n < NB; n++) w_mask[8*n +: 8] = {8{r_sel[RD_LAT-1][n]}};
  end

  assign o_wb_ack   = r_vld[RD_LAT-1] & ~r_err[RD_LAT-1];
  assign o_wb_err   = r_vld[RD_LAT-1] &  r_err[RD_LAT-1];
  assign o_wb_data  = o_wb_ack ? (w_a_data & w_mask) : '0;
  assign o_wb_stall = 1'b0;
  assign o_b_coll   = r_b_coll;

endmodule

// File: tb/tb_wb_bram_pipelined.sv
// Directed self-checking bench: RD_LAT=1 and RD_LAT=2 instances share all inputs.
module tb_wb_bram_pipelined;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cyc, stb, we;
  logic [31:0] addr, wdata;
  logic [3:0]  sel;
  logic        b_en;
  logic [3:0]  b_we;
  logic [10:0] b_addr;
  logic [31:0] b_wd;

  logic        ack1, err1, stall1, coll1;
  logic [31:0] data1, b_rd1;
  logic        ack2, err2, stall2, coll2;
  logic [31:0] data2, b_rd2;

  int n_checks = 0;
  int n_fail = 0;

  logic        s1_ack, s1_err, p1_ack, p1_err, s2_ack, s2_err;
  logic [31:0] s1_data, p1_data, s2_data;

  always #5 clk = ~clk;

  wb_bram_pipelined #(.DATA_W(32), .SIZE_BYTE(8192), .START_ADDR(32'h20000000), .RD_LAT(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_addr(addr), .i_wb_we(we),
    .i_wb_data(wdata), .i_wb_sel(sel), .o_wb_ack(ack1), .o_wb_err(err1), .o_wb_data(data1),
    .o_wb_stall(stall1), .i_b_en(b_en), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wd(b_wd),
    .o_b_rd(b_rd1), .o_b_coll(coll1));

  wb_bram_pipelined #(.DATA_W(32), .SIZE_BYTE(8192), .START_ADDR(32'h20000000), .RD_LAT(2)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_addr(addr), .i_wb_we(we),
    .i_wb_data(wdata), .i_wb_sel(sel), .o_wb_ack(ack2), .o_wb_err(err2), .o_wb_data(data2),
    .o_wb_stall(stall2), .i_b_en(b_en), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wd(b_wd),
    .o_b_rd(b_rd2), .o_b_coll(coll2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc = 0; stb = 0; we = 0; addr = 0; wdata = 0; sel = 0;
    b_en = 0; b_we = 0; b_addr = 0; b_wd = 0;
  endtask

  // One Wishbone request; captures RD_LAT=1 response, the cycle after it, and RD_LAT=2 response.
  task automatic wb_single(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cyc = 1; stb = 1; we = w; addr = a; wdata = d; sel = s;
    tick();
    s1_ack = ack1; s1_err = err1; s1_data = data1;
    stb = 0; we = 0;
    tick();
    p1_ack = ack1; p1_err = err1; p1_data = data1;
    s2_ack = ack2; s2_err = err2; s2_data = data2;
    cyc = 0;
  endtask

  task automatic b_write(input logic [10:0] a, input logic [31:0] d, input logic [3:0] m);
    b_en = 1; b_we = m; b_addr = a; b_wd = d;
    tick();
    b_en = 0; b_we = 0;
  endtask

  task automatic test_reset();
    idle();
    #2 rst_n = 0;
    tick(); tick();
    n_checks++; if ({ack1, err1, coll1, stall1} !== 4'b0) begin n_fail++; $display("FAIL reset_flags1: got %b required 0000", {ack1, err1, coll1, stall1}); end
    n_checks++; if (data1 !== 32'h0) begin n_fail++; $display("FAIL reset_data1: got %h required 0", data1); end
    n_checks++; if (b_rd1 !== 32'h0) begin n_fail++; $display("FAIL reset_brd1: got %h required 0", b_rd1); end
    n_checks++; if ({ack2, err2, coll2, stall2} !== 4'b0) begin n_fail++; $display("FAIL reset_flags2: got %b required 0000", {ack2, err2, coll2, stall2}); end
    n_checks++; if ({data2, b_rd2} !== 64'h0) begin n_fail++; $display("FAIL reset_data2: got %h required 0", {data2, b_rd2}); end
    rst_n = 1;
    tick();
  endtask

  task automatic test_word_rw();
    wb_single(1, 32'h20000010, 32'hDEADBEEF, 4'hF);
    n_checks++; if ({s1_ack, s1_err} !== 2'b10) begin n_fail++; $display("FAIL wr_ack1: got ack/err %b%b required 10", s1_ack, s1_err); end
    n_checks++; if (s1_data !== 32'h0) begin n_fail++; $display("FAIL wr_ack_data: got %h required 0", s1_data); end
    n_checks++; if ({s2_ack, s2_err} !== 2'b10) begin n_fail++; $display("FAIL wr_ack2: got ack/err %b%b required 10", s2_ack, s2_err); end
    wb_single(0, 32'h20000010, 32'h0, 4'hF);
    n_checks++; if (s1_ack !== 1'b1) begin n_fail++; $display("FAIL rd_ack1: got %b required 1", s1_ack); end
    n_checks++; if (s1_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data1: got %h required deadbeef", s1_data); end
    n_checks++; if ({p1_ack, p1_err, p1_data} !== 34'h0) begin n_fail++; $display("FAIL rd_idle1: got ack %b err %b data %h required all 0", p1_ack, p1_err, p1_data); end
    n_checks++; if (s2_ack !== 1'b1 || s2_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data2: got ack %b data %h required 1 deadbeef", s2_ack, s2_data); end
  endtask

  task automatic test_byte_lanes();
    wb_single(1, 32'h20000020, 32'h12345678, 4'hF);
    wb_single(1, 32'h20000020, 32'h000000AA, 4'h1);
    wb_single(1, 32'h20000022, 32'h0000BB00, 4'h2);
    wb_single(0, 32'h20000020, 32'h0, 4'hF);
    n_checks++; if (s1_data !== 32'h1234BBAA) begin n_fail++; $display("FAIL lanes_full: got %h required 1234bbaa", s1_data); end
    wb_single(0, 32'h20000020, 32'h0, 4'h3);
    n_checks++; if (s1_data !== 32'h0000BBAA) begin n_fail++; $display("FAIL lanes_masked1: got %h required 0000bbaa", s1_data); end
    n_checks++; if (s2_data !== 32'h0000BBAA) begin n_fail++; $display("FAIL lanes_masked2: got %h required 0000bbaa", s2_data); end
  endtask

  task automatic test_port_b();
    for (int k = 0; k < 8; k++) b_write(11'(16 + k), 32'hC0DE0000 + 32'(16 + k), 4'hF);
    b_en = 1; b_we = 0; b_addr = 11'd19;
    tick();
    n_checks++; if (b_rd1 !== 32'hC0DE0013) begin n_fail++; $display("FAIL b_read1: got %h required c0de0013", b_rd1); end
    b_en = 0;
    tick();
    n_checks++; if (b_rd2 !== 32'hC0DE0013) begin n_fail++; $display("FAIL b_read2: got %h required c0de0013", b_rd2); end
    wb_single(0, 32'h2000005C, 32'h0, 4'hF);
    n_checks++; if (s1_data !== 32'hC0DE0017) begin n_fail++; $display("FAIL b_to_wb: got %h required c0de0017", s1_data); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d;
    cyc = 1; stb = 1; we = 0; sel = 4'hF;
    for (int s = 0; s < 10; s++) begin
      if (s < 8) addr = 32'h20000040 + 32'(4 * s);
      else stb = 0;
      tick();
      n_checks++; if (stall1 !== 1'b0 || stall2 !== 1'b0) begin n_fail++; $display("FAIL burst_stall s%0d: got %b%b required 00", s, stall1, stall2); end
      exp_d = 32'hC0DE0000 + 32'(16 + s);
      if (s < 8) begin
        n_checks++; if (ack1 !== 1'b1 || data1 !== exp_d) begin n_fail++; $display("FAIL burst1 s%0d: got ack %b data %h required 1 %h", s, ack1, data1, exp_d); end
      end
      exp_d = 32'hC0DE0000 + 32'(15 + s);
      if (s >= 1 && s <= 8) begin
        n_checks++; if (ack2 !== 1'b1 || data2 !== exp_d) begin n_fail++; $display("FAIL burst2 s%0d: got ack %b data %h required 1 %h", s, ack2, data2, exp_d); end
      end else begin
        n_checks++; if (ack2 !== 1'b0 || data2 !== 32'h0) begin n_fail++; $display("FAIL burst2_idle s%0d: got ack %b data %h required 0 0", s, ack2, data2); end
      end
    end
    cyc = 0;
  endtask

  task automatic test_error();
    wb_single(1, 32'h20000000, 32'hCAFEF00D, 4'hF);
    wb_single(1, 32'h20002000, 32'hFFFFFFFF, 4'hF);
    n_checks++; if ({s1_ack, s1_err} !== 2'b01) begin n_fail++; $display("FAIL err_write: got ack/err %b%b required 01", s1_ack, s1_err); end
    wb_single(0, 32'h20002000, 32'h0, 4'hF);
    n_checks++; if ({s1_ack, s1_err} !== 2'b01 || s1_data !== 32'h0) begin n_fail++; $display("FAIL err_read1: got ack/err %b%b data %h required 01 0", s1_ack, s1_err, s1_data); end
    n_checks++; if ({p1_ack, p1_err} !== 2'b00) begin n_fail++; $display("FAIL err_pulse: got ack/err %b%b required 00", p1_ack, p1_err); end
    n_checks++; if ({s2_ack, s2_err} !== 2'b01 || s2_data !== 32'h0) begin n_fail++; $display("FAIL err_read2: got ack/err %b%b data %h required 01 0", s2_ack, s2_err, s2_data); end
    wb_single(0, 32'h1FFFFFFC, 32'h0, 4'hF);
    n_checks++; if ({s1_ack, s1_err} !== 2'b01) begin n_fail++; $display("FAIL err_below: got ack/err %b%b required 01", s1_ack, s1_err); end
    wb_single(0, 32'h20000000, 32'h0, 4'hF);
    n_checks++; if (s1_data !== 32'hCAFEF00D) begin n_fail++; $display("FAIL err_unchanged: got %h required cafef00d", s1_data); end
  endtask

  task automatic test_abort();
    cyc = 1; stb = 1; we = 0; sel = 4'hF; addr = 32'h20000040;
    tick();
    n_checks++; if (ack1 !== 1'b1 || data1 !== 32'hC0DE0010) begin n_fail++; $display("FAIL abort_r0: got ack %b data %h required 1 c0de0010", ack1, data1); end
    addr = 32'h20000044;
    tick();
    n_checks++; if (ack1 !== 1'b1 || ack2 !== 1'b1) begin n_fail++; $display("FAIL abort_r1: got ack1 %b ack2 %b required 1 1", ack1, ack2); end
    cyc = 0; addr = 32'h20000048;
    for (int s = 0; s < 2; s++) begin
      tick();
      n_checks++; if ({ack1, err1, ack2, err2} !== 4'b0 || data1 !== 32'h0) begin n_fail++; $display("FAIL abort_quiet s%0d: got ack1/err1/ack2/err2 %b data %h required 0000 0", s, {ack1, err1, ack2, err2}, data1); end
    end
    stb = 0;
  endtask

  task automatic test_collision();
    b_write(11'd32, 32'h0, 4'hF);
    tick();
    cyc = 1; stb = 1; we = 1; addr = 32'h20000080; wdata = 32'h11111111; sel = 4'hF;
    b_en = 1; b_we = 4'hF; b_addr = 11'd32; b_wd = 32'h22222222;
    tick();
    n_checks++; if (coll1 !== 1'b1 || coll2 !== 1'b1) begin n_fail++; $display("FAIL coll_pulse: got %b%b required 11", coll1, coll2); end
    n_checks++; if (b_rd1 !== 32'h0) begin n_fail++; $display("FAIL coll_read_first: got %h required 0", b_rd1); end
    idle();
    tick();
    n_checks++; if (coll1 !== 1'b0) begin n_fail++; $display("FAIL coll_one_cycle: got %b required 0", coll1); end
    wb_single(0, 32'h20000080, 32'h0, 4'hF);
    n_checks++; if (s1_data !== 32'h11111111) begin n_fail++; $display("FAIL coll_wb_wins: got %h required 11111111", s1_data); end
    cyc = 1; stb = 1; we = 1; addr = 32'h20000080; wdata = 32'h11111111; sel = 4'h7;
    b_en = 1; b_we = 4'h8; b_addr = 11'd32; b_wd = 32'h22222222;
    tick();
    n_checks++; if (coll1 !== 1'b0) begin n_fail++; $display("FAIL coll_disjoint: got %b required 0", coll1); end
    n_checks++; if (b_rd1 !== 32'h11111111) begin n_fail++; $display("FAIL coll_b_old: got %h required 11111111", b_rd1); end
    idle();
    tick();
    wb_single(0, 32'h20000080, 32'h0, 4'hF);
    n_checks++; if (s1_data !== 32'h22111111) begin n_fail++; $display("FAIL coll_merge: got %h required 22111111", s1_data); end
  endtask

  task automatic test_reset_mid();
    cyc = 1; stb = 1; we = 0; sel = 4'hF; addr = 32'h20000010;
    tick();
    stb = 0;
    n_checks++; if (ack1 !== 1'b1) begin n_fail++; $display("FAIL mid_pre_ack: got %b required 1", ack1); end
    rst_n = 0;
    #1;
    n_checks++; if ({ack1, ack2, err1, err2} !== 4'b0 || {data1, data2} !== 64'h0) begin n_fail++; $display("FAIL mid_async_clear: got flags %b data %h required 0", {ack1, ack2, err1, err2}, {data1, data2}); end
    idle();
    tick();
    rst_n = 1;
    tick();
    n_checks++; if ({ack1, ack2} !== 2'b00) begin n_fail++; $display("FAIL mid_after: got %b required 00", {ack1, ack2}); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_port_b();
    test_back_to_back();
    test_error();
    test_abort();
    test_collision();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
